// File: rtl/mini_alu_pkg.sv
// Shared opcodes, instruction field layout and sizing helpers for the mini ALU core.
package mini_alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_STO  = 4'h3,
    OP_BLE  = 4'h4,
    OP_BNE  = 4'h5,
    OP_JMP  = 4'h6,
    OP_CALL = 4'h7,
    OP_RET  = 4'h8,
    OP_INC  = 4'h9,
    OP_ADDI = 4'hA,
    OP_MUL  = 4'hB,
    OP_MULI = 4'hC,
    OP_SHL  = 4'hD,
    OP_SHR  = 4'hE,
    OP_LED  = 4'hF
  } op_e;

  // Field index: 0 = src0, 1 = src1, 2 = dst, 3 = opcode.
  function automatic int f_fld_lsb(input int addr_w, input int idx);
    return idx * addr_w;
  endfunction

  function automatic int f_instr_w(input int addr_w);
    return 4 + 3 * addr_w;
  endfunction

  function automatic int f_lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mini_alu_ret_stack.sv
// Hardware return-address LIFO: pushes past full and pops from empty are dropped
// and recorded in sticky flags that clear only on reset.
module mini_alu_ret_stack
  import mini_alu_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int IP_W        = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_push,
  input  logic                              i_pop,
  input  logic [IP_W-1:0]                   i_data,
  output logic [IP_W-1:0]                   o_top,
  output logic                              o_empty,
  output logic [f_lvl_w(STACK_DEPTH)-1:0]   o_level,
  output logic                              o_ovf,
  output logic                              o_unf
);

  localparam int LW    = f_lvl_w(STACK_DEPTH);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [IP_W-1:0] r_mem [STACK_DEPTH];
  logic [LW-1:0]   r_level;
  logic            r_ovf;
  logic            r_unf;
  logic            w_full;

  assign w_full  = (r_level == LW'(STACK_DEPTH));
  assign o_empty = (r_level == '0);
  assign o_top   = r_mem[IDX_W'(r_level - LW'(1))];
  assign o_level = r_level;
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (i_push) begin
      if (w_full) r_ovf <= 1'b1;
      else        r_level <= r_level + LW'(1);
    end else if (i_pop) begin
      if (o_empty) r_unf <= 1'b1;
      else         r_level <= r_level - LW'(1);
    end
  end

  // Entry storage needs no reset: only slots below the level are ever read.
  always_ff @(posedge i_clk) begin
    if (i_push && !w_full) r_mem[IDX_W'(r_level)] <= i_data;
  end

endmodule

// File: rtl/mini_alu_core_v2.sv
// Two-stage fetch/execute mini CPU core with register file, return stack and stall.
// Define MINI_ALU_BYPASS_EN to forward the execute-stage write into the fetched operands.
module mini_alu_core_v2
  import mini_alu_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int IP_W        = 16,
  parameter int REG_DEPTH   = 16,
  parameter int STACK_DEPTH = 4,
  parameter int LED_W       = 8
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic                              iStall,
  input  logic [f_instr_w(ADDR_W)-1:0]      iInstruction,
  output logic [IP_W-1:0]                   oIP,
  output logic [LED_W-1:0]                  oLed,
  output logic                              oStackOvf,
  output logic                              oStackUnf,
  output logic [f_lvl_w(STACK_DEPTH)-1:0]   oStackLevel
);

  localparam int SRC0_LSB = f_fld_lsb(ADDR_W, 0);
  localparam int SRC1_LSB = f_fld_lsb(ADDR_W, 1);
  localparam int DST_LSB  = f_fld_lsb(ADDR_W, 2);
  localparam int OP_LSB   = f_fld_lsb(ADDR_W, 3);
  localparam int SH_W     = $clog2(DATA_W);
  localparam int RIDX_W   = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam logic [ADDR_W:0] REG_LIM = (ADDR_W+1)'(REG_DEPTH);

  op_e               r_op;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_src1;
  logic [ADDR_W-1:0] r_src0;
  logic [DATA_W-1:0] r_a1;
  logic [DATA_W-1:0] r_a0;
  logic [IP_W-1:0]   r_ip;
  logic [LED_W-1:0]  r_led;
  logic [DATA_W-1:0] r_regs [REG_DEPTH];

  op_e                 w_f_op;
  logic [ADDR_W-1:0]   w_f_dst;
  logic [ADDR_W-1:0]   w_f_src1;
  logic [ADDR_W-1:0]   w_f_src0;
  logic [DATA_W-1:0]   w_rd1;
  logic [DATA_W-1:0]   w_rd0;
  logic [2*ADDR_W-1:0] w_imm_raw;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_src0_ext;
  logic [SH_W-1:0]     w_sh;
  logic [DATA_W-1:0]   w_res;
  logic                w_wr;
  logic                w_rf_we;
  logic                w_taken;
  logic [IP_W-1:0]     w_target;
  logic                w_push;
  logic                w_pop;
  logic                w_led_we;
  logic [IP_W-1:0]     w_stk_top;
  logic                w_stk_empty;
  logic [IP_W-1:0]     w_ip_next;

  assign w_f_op   = op_e'(iInstruction[OP_LSB +: 4]);
  assign w_f_dst  = iInstruction[DST_LSB +: ADDR_W];
  assign w_f_src1 = iInstruction[SRC1_LSB +: ADDR_W];
  assign w_f_src0 = iInstruction[SRC0_LSB +: ADDR_W];

  assign w_imm_raw  = {r_src1, r_src0};
  assign w_imm      = DATA_W'(w_imm_raw);
  assign w_src0_ext = DATA_W'(r_src0);
  assign w_sh       = r_src0[SH_W-1:0];

  always_comb begin
    w_res    = '0;
    w_wr     = 1'b0;
    w_taken  = 1'b0;
    w_target = IP_W'(r_dst);
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_led_we = 1'b0;
    case (r_op)
      OP_ADD:  begin w_wr = 1'b1; w_res = r_a1 + r_a0;         end
      OP_SUB:  begin w_wr = 1'b1; w_res = r_a1 - r_a0;         end
      OP_STO:  begin w_wr = 1'b1; w_res = w_imm;               end
      OP_BLE:  w_taken = (r_a1 <= r_a0);
      OP_BNE:  w_taken = (r_a1 != r_a0);
      OP_JMP:  w_taken = 1'b1;
      OP_CALL: begin w_taken = 1'b1; w_push = 1'b1;            end
      // An empty-stack return falls through to the sequential address.
      OP_RET:  begin w_pop = 1'b1; w_taken = ~w_stk_empty; w_target = w_stk_top; end
      OP_INC:  begin w_wr = 1'b1; w_res = r_a1 + DATA_W'(1);   end
      OP_ADDI: begin w_wr = 1'b1; w_res = r_a1 + w_src0_ext;   end
      OP_MUL:  begin w_wr = 1'b1; w_res = r_a1 * r_a0;         end
      OP_MULI: begin w_wr = 1'b1; w_res = r_a1 * w_src0_ext;   end
      OP_SHL:  begin w_wr = 1'b1; w_res = r_a1 << w_sh;        end
      OP_SHR:  begin w_wr = 1'b1; w_res = r_a1 >> w_sh;        end
      OP_LED:  w_led_we = 1'b1;
      default: ;
    endcase
  end

  assign w_rf_we   = w_wr & ({1'b0, r_dst} < REG_LIM);
  assign oIP       = w_taken ? w_target : r_ip;
  assign w_ip_next = oIP + IP_W'(1);

  always_comb begin
    w_rd1 = '0;
    w_rd0 = '0;
    if ({1'b0, w_f_src1} < REG_LIM) w_rd1 = r_regs[w_f_src1[RIDX_W-1:0]];
    if ({1'b0, w_f_src0} < REG_LIM) w_rd0 = r_regs[w_f_src0[RIDX_W-1:0]];
`ifdef MINI_ALU_BYPASS_EN
    if (w_rf_we && (r_dst == w_f_src1)) w_rd1 = w_res;
    if (w_rf_we && (r_dst == w_f_src0)) w_rd0 = w_res;
`endif
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_ip   <= '0;
      r_op   <= OP_NOP;
      r_dst  <= '0;
      r_src1 <= '0;
      r_src0 <= '0;
      r_a1   <= '0;
      r_a0   <= '0;
      r_led  <= '0;
      for (int i = 0; i < REG_DEPTH; i++) r_regs[i] <= '0;
    end else if (!iStall) begin
      r_ip   <= w_ip_next;
      r_op   <= w_f_op;
      r_dst  <= w_f_dst;
      r_src1 <= w_f_src1;
      r_src0 <= w_f_src0;
      r_a1   <= w_rd1;
      r_a0   <= w_rd0;
      if (w_rf_we)  r_regs[r_dst[RIDX_W-1:0]] <= w_res;
      if (w_led_we) r_led <= r_a1[LED_W-1:0];
    end
  end

  assign oLed = r_led;

  mini_alu_ret_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .IP_W        (IP_W)
  ) u_ret_stack (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_push  (w_push & ~iStall),
    .i_pop   (w_pop & ~iStall),
    .i_data  (r_ip),
    .o_top   (w_stk_top),
    .o_empty (w_stk_empty),
    .o_level (oStackLevel),
    .o_ovf   (oStackOvf),
    .o_unf   (oStackUnf)
  );

endmodule

// File: tb/tb_mini_alu_core_v2.sv
// Directed-program bench for mini_alu_core_v2 with an instruction-level reference model.
module tb_mini_alu_core_v2;

`ifdef MINI_ALU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [3:0] K_NOP = 4'h0, K_ADD = 4'h1, K_SUB = 4'h2, K_STO = 4'h3,
                         K_BLE = 4'h4, K_BNE = 4'h5, K_JMP = 4'h6, K_CALL = 4'h7,
                         K_RET = 4'h8, K_MULI = 4'hC, K_SHL = 4'hD, K_SHR = 4'hE,
                         K_LED = 4'hF, K_INC = 4'h9;

  logic        Clock;
  logic        Reset;
  logic        iStall;
  logic [27:0] iInstruction;
  logic [15:0] oIP;
  logic [7:0]  oLed;
  logic        oStackOvf;
  logic        oStackUnf;
  logic [2:0]  oStackLevel;

  logic [27:0] rom [256];
  int n_cmp = 0;
  int n_bad = 0;

  assign iInstruction = rom[oIP[7:0]];

  mini_alu_core_v2 dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iStall       (iStall),
    .iInstruction (iInstruction),
    .oIP          (oIP),
    .oLed         (oLed),
    .oStackOvf    (oStackOvf),
    .oStackUnf    (oStackUnf),
    .oStackLevel  (oStackLevel)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one program-order instruction in flight plus the
  // operands it captured when it was fetched.
  logic [15:0] m_regs [16];
  logic [3:0]  m_op;
  logic [7:0]  m_dst, m_s1, m_s0;
  logic [15:0] m_a1, m_a0;
  logic [7:0]  m_led;
  int          m_pc;
  int          m_stk[$];
  bit          m_ovf, m_unf;

  function automatic logic [15:0] m_rd(input logic [7:0] a);
    return (a < 8'd16) ? m_regs[a[3:0]] : 16'h0000;
  endfunction

  function automatic int m_next();
    bit tk;
    int tg;
    tk = 1'b0;
    tg = int'(m_dst);
    case (m_op)
      K_BLE:         tk = (m_a1 <= m_a0);
      K_BNE:         tk = (m_a1 != m_a0);
      K_JMP, K_CALL: tk = 1'b1;
      K_RET: begin
        tk = (m_stk.size() > 0);
        if (tk) tg = m_stk[$];
      end
      default:       tk = 1'b0;
    endcase
    return tk ? tg : (m_pc + 1) % 65536;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_op = K_NOP; m_dst = '0; m_s1 = '0; m_s0 = '0;
    m_a1 = '0; m_a0 = '0; m_led = '0;
    m_pc = -1;
    m_stk.delete();
    m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic m_step();
    int na;
    logic [27:0] ins;
    logic [15:0] p1, p0;
    logic [31:0] res;
    bit we;
    int sh;
    na = m_next();
    we = 1'b1;
    res = '0;
    sh = int'(m_s0) % 16;
    case (m_op)
      4'h1: res = m_a1 + m_a0;
      4'h2: res = m_a1 - m_a0;
      4'h3: res = {m_s1, m_s0};
      4'h9: res = m_a1 + 1;
      4'hA: res = m_a1 + m_s0;
      4'hB: res = m_a1 * m_a0;
      4'hC: res = m_a1 * m_s0;
      4'hD: res = m_a1 << sh;
      4'hE: res = m_a1 >> sh;
      default: we = 1'b0;
    endcase
    if (m_op == K_CALL) begin
      if (m_stk.size() < 4) m_stk.push_back((m_pc + 1) % 65536);
      else m_ovf = 1'b1;
    end
    if (m_op == K_RET) begin
      if (m_stk.size() > 0) void'(m_stk.pop_back());
      else m_unf = 1'b1;
    end
    if (m_op == K_LED) m_led = m_a1[7:0];
    ins = rom[na % 256];
    p1 = m_rd(ins[15:8]);
    p0 = m_rd(ins[7:0]);
    if (we && m_dst < 8'd16) m_regs[m_dst[3:0]] = res[15:0];
    if (BYP) begin
      p1 = m_rd(ins[15:8]);
      p0 = m_rd(ins[7:0]);
    end
    m_op = ins[27:24]; m_dst = ins[23:16]; m_s1 = ins[15:8]; m_s0 = ins[7:0];
    m_a1 = p1; m_a0 = p0;
    m_pc = na;
  endtask

  always @(posedge Clock or posedge Reset) begin
    if (Reset) m_reset();
    else if (!iStall) m_step();
  end

  always @(negedge Clock) begin
    chk("ip", 32'(oIP), 32'(m_next()));
    chk("led", 32'(oLed), 32'(m_led));
    chk("level", 32'(oStackLevel), 32'(m_stk.size()));
    chk("ovf", 32'(oStackOvf), 32'(m_ovf));
    chk("unf", 32'(oStackUnf), 32'(m_unf));
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
    #1;
  endtask

  task automatic ld(input int a, input logic [3:0] op, input logic [7:0] d,
                    input logic [7:0] s1, input logic [7:0] s0);
    rom[a] = {op, d, s1, s0};
  endtask

  task automatic start_test();
    Reset  = 1'b1;
    iStall = 1'b0;
    @(negedge Clock); #1;
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic go();
    @(negedge Clock); #1;
    Reset = 1'b0;
  endtask

  initial begin
    Reset  = 1'b0;
    iStall = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    #1 Reset = 1'b1;

    // 1: reset values, then SUB wrapping below zero
    start_test();
    chk("rst_ip", 32'(oIP), 32'h0);
    chk("rst_led", 32'(oLed), 32'h0);
    chk("rst_ovf", 32'(oStackOvf), 32'h0);
    chk("rst_unf", 32'(oStackUnf), 32'h0);
    chk("rst_level", 32'(oStackLevel), 32'h0);
    ld(0, K_STO, 1, 8'h00, 8'h05);
    ld(1, K_STO, 2, 8'h00, 8'h03);
    ld(2, K_NOP, 0, 0, 0);
    ld(3, K_SUB, 3, 2, 1);
    ld(4, K_NOP, 0, 0, 0);
    ld(5, K_LED, 0, 3, 0);
    ld(6, K_JMP, 6, 0, 0);
    go();
    step(7);
    chk("t1_sub_led", 32'(oLed), 32'hFE);

    // 2: shifts and truncating multiply
    start_test();
    ld(0, K_STO, 1, 8'h00, 8'h01);
    ld(2, K_SHL, 2, 1, 15);
    ld(4, K_SHR, 3, 2, 15);
    ld(5, K_MULI, 4, 2, 2);
    ld(6, K_SHR, 5, 2, 8);
    ld(7, K_LED, 0, 3, 0);
    ld(8, K_LED, 0, 4, 0);
    ld(9, K_LED, 0, 5, 0);
    ld(10, K_JMP, 10, 0, 0);
    go();
    step(9);
    chk("t2_shr_r3", 32'(oLed), 32'h01);
    step(1);
    chk("t2_muli_r4", 32'(oLed), 32'h00);
    step(1);
    chk("t2_shl_r2_hi", 32'(oLed), 32'h80);

    // 3: reset mid-run, then call chain deeper than the stack
    start_test();
    chk("t3_rst_led", 32'(oLed), 32'h0);
    ld(0, K_CALL, 10, 0, 0);
    ld(10, K_CALL, 20, 0, 0);
    ld(20, K_CALL, 30, 0, 0);
    ld(30, K_CALL, 40, 0, 0);
    ld(40, K_CALL, 50, 0, 0);
    ld(50, K_RET, 0, 0, 0);
    ld(31, K_RET, 0, 0, 0);
    ld(21, K_RET, 0, 0, 0);
    ld(11, K_RET, 0, 0, 0);
    ld(1, K_RET, 0, 0, 0);
    ld(2, K_JMP, 2, 0, 0);
    go();
    step(5);
    chk("t3_full_level", 32'(oStackLevel), 32'd4);
    chk("t3_5th_call_ip", 32'(oIP), 32'd50);
    step(1);
    chk("t3_ovf", 32'(oStackOvf), 32'h1);
    chk("t3_ret1_ip", 32'(oIP), 32'd31);
    step(1);
    chk("t3_ret2_ip", 32'(oIP), 32'd21);
    step(1);
    chk("t3_ret3_ip", 32'(oIP), 32'd11);
    step(1);
    chk("t3_ret4_ip", 32'(oIP), 32'd1);
    step(1);
    chk("t3_ret5_fall_ip", 32'(oIP), 32'd2);
    chk("t3_empty_level", 32'(oStackLevel), 32'd0);
    step(1);
    chk("t3_unf", 32'(oStackUnf), 32'h1);

    // 4: BNE equal falls through, BLE equal taken, shadow slot never writes
    start_test();
    ld(0, K_STO, 1, 8'h00, 8'h03);
    ld(1, K_STO, 2, 8'h00, 8'h03);
    ld(3, K_BNE, 9, 1, 2);
    ld(4, K_BLE, 8, 1, 2);
    ld(5, K_STO, 3, 8'h00, 8'h77);
    ld(8, K_LED, 0, 3, 0);
    ld(9, K_JMP, 9, 0, 0);
    go();
    step(4);
    chk("t4_bne_ip", 32'(oIP), 32'd4);
    step(1);
    chk("t4_ble_ip", 32'(oIP), 32'd8);
    step(1);
    chk("t4_after_ip", 32'(oIP), 32'd9);
    step(1);
    chk("t4_led_r3", 32'(oLed), 32'h00);

    // 5: stall held across a taken JMP
    start_test();
    ld(0, K_STO, 1, 8'h00, 8'h11);
    ld(2, K_JMP, 6, 0, 0);
    ld(3, K_STO, 1, 8'h00, 8'h22);
    ld(6, K_INC, 1, 1, 0);
    ld(8, K_LED, 0, 1, 0);
    ld(9, K_JMP, 9, 0, 0);
    go();
    step(3);
    chk("t5_jmp_ip", 32'(oIP), 32'd6);
    iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t5_stall_ip", 32'(oIP), 32'd6);
    end
    iStall = 1'b0;
    step(4);
    chk("t5_led_r1", 32'(oLed), 32'h12);

    // 6: back-to-back dependency
    start_test();
    ld(0, K_STO, 1, 8'h00, 8'h04);
    ld(2, K_ADD, 2, 1, 1);
    ld(3, K_LED, 0, 2, 0);
    ld(4, K_JMP, 4, 0, 0);
    go();
    step(5);
    chk("t6_dep_led", 32'(oLed), BYP ? 32'h08 : 32'h00);

    // 7: register addresses beyond the file
    start_test();
    ld(0, K_STO, 4, 8'h00, 8'h44);
    ld(1, K_STO, 20, 8'h00, 8'h55);
    ld(2, K_STO, 1, 8'h00, 8'h99);
    ld(4, K_LED, 0, 1, 0);
    ld(5, K_LED, 0, 20, 0);
    ld(6, K_LED, 0, 4, 0);
    ld(7, K_JMP, 7, 0, 0);
    go();
    step(6);
    chk("t7_led_r1", 32'(oLed), 32'h99);
    step(1);
    chk("t7_led_r20", 32'(oLed), 32'h00);
    step(1);
    chk("t7_led_r4", 32'(oLed), 32'h44);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
